// File: rtl/neuron_lanes_if.sv
// Stream bundle for neuron_lanes: shared input beats with per-lane weights/bias in,
// per-lane result vector out, each side under its own valid/ready handshake.
interface neuron_lanes_if #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [IN_WIDTH-1:0]    data_in;
  logic [LANES*IN_WIDTH-1:0]     weight_in;
  logic [LANES*IN_WIDTH-1:0]     bias_in;
  logic [1:0]                    act_mode;
  logic                          round_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*OUT_WIDTH-1:0]    data_out;
  logic [LANES-1:0]              sat_flags;

  modport master (
    output in_valid, data_in, weight_in, bias_in, act_mode, round_en, out_ready,
    input  in_ready, out_valid, data_out, sat_flags
  );

  modport slave (
    input  in_valid, data_in, weight_in, bias_in, act_mode, round_en, out_ready,
    output in_ready, out_valid, data_out, sat_flags
  );
endinterface

// File: rtl/neuron_lanes.sv
// LANES parallel serial neurons sharing one input stream: per-lane MAC over NUM_INPUTS
// beats, then bias, optional rounding, shift, activation and saturation in one FINAL cycle.
module neuron_lanes #(
  parameter int LANES      = 4,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int NUM_INPUTS = 784,
  parameter int FRAC_BITS  = 15,
  parameter int OUT_SHIFT  = 15
) (
  input logic           clk,
  input logic           rst,
  neuron_lanes_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ACCUM = 2'd0, FINAL = 2'd1, HOLD = 2'd2} state_t;

  state_t                      state_q;
  logic [CNT_W-1:0]            count_q;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [LANES];
  logic [LANES*OUT_WIDTH-1:0]  data_out_q, data_out_d;
  logic [LANES-1:0]            sat_q, sat_d;
  logic                        out_valid_q;
  logic signed [2*IN_WIDTH-1:0] prod;
  logic [OUT_WIDTH:0]          sres;

  function automatic logic signed [ACC_WIDTH-1:0] align_round(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [IN_WIDTH-1:0]         bias,
    input logic                        rnd
  );
    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] s;
    b_ext = {{(ACC_WIDTH-IN_WIDTH){bias[IN_WIDTH-1]}}, bias};
    s = acc + (b_ext <<< FRAC_BITS);
    if (rnd) s = s + HALF;
    return s >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] activate(
    input logic signed [ACC_WIDTH-1:0] t,
    input logic [1:0]                  mode
  );
    case (mode)
      2'b00:   return t;
      2'b10:   return t[ACC_WIDTH-1] ? (t >>> 3) : t;
      default: return t[ACC_WIDTH-1] ? '0 : t;
    endcase
  endfunction

  // Result packs {clamped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] y);
    if (y > SAT_MAX)      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (y < SAT_MIN) return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                  return {1'b0, y[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    acc_d      = acc_q;
    data_out_d = '0;
    sat_d      = '0;
    prod       = '0;
    sres       = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = (2*IN_WIDTH)'($signed(bus.data_in)) *
             (2*IN_WIDTH)'($signed(bus.weight_in[i*IN_WIDTH +: IN_WIDTH]));
      acc_d[i] = acc_q[i] + {{(ACC_WIDTH-2*IN_WIDTH){prod[2*IN_WIDTH-1]}}, prod};
      sres = saturate(activate(align_round(acc_q[i], bus.bias_in[i*IN_WIDTH +: IN_WIDTH],
                                           bus.round_en), bus.act_mode));
      sat_d[i] = sres[OUT_WIDTH];
      data_out_d[i*OUT_WIDTH +: OUT_WIDTH] = sres[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      acc_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= '0;
    end else begin
      case (state_q)
        ACCUM: if (bus.in_valid) begin
          acc_q <= acc_d;
          if (count_q == LAST_BEAT) begin
            count_q <= '0;
            state_q <= FINAL;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        FINAL: begin
          data_out_q  <= data_out_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          acc_q       <= '{default: '0};
          state_q     <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.sat_flags = sat_q;
endmodule

// File: tb/tb_neuron_lanes.sv
// Directed bench for neuron_lanes (2 lanes, 4-beat vectors): expected vectors are queued
// when a vector is driven and popped when the result is presented.
module tb_neuron_lanes;
  localparam int LANES = 2, IW = 16, OW = 16;

  typedef struct packed {
    logic [LANES*OW-1:0] data;
    logic [LANES-1:0]    flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  neuron_lanes_if #(.LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  neuron_lanes #(
    .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW), .ACC_WIDTH(48),
    .NUM_INPUTS(4), .FRAC_BITS(15), .OUT_SHIFT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1);
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.weight_in = {w1, w0};
    step();
    bus.in_valid  = 1'b0;
  endtask

  // Drives one 4-beat vector, checks exact latency, HOLD behaviour and the result.
  task automatic run_vec(input string tag, input logic [63:0] dv,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [1:0] mode, input logic rnd,
                         input int gap, input int hold, input logic early,
                         input logic [15:0] e0, input logic [15:0] e1,
                         input logic [1:0] ef);
    exp_t e;
    sb.push_back('{data: {e1, e0}, flags: ef});
    bus.bias_in   = {b1, b0};
    bus.act_mode  = mode;
    bus.round_en  = rnd;
    bus.out_ready = early;
    for (int b = 0; b < 4; b++) begin
      beat(dv[b*16 +: 16], w0, w1);
      if (b < 3) repeat (gap) step();
    end
    chk({tag, "/final_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "/final_ready"}, 64'(bus.in_ready), 64'd0);
    step();
    chk({tag, "/valid"}, 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < hold; k++) begin
      bus.out_ready = 1'b0;
      step();
      chk({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "/hold_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "/hold_data"}, 64'(bus.data_out), 64'(sb[0].data));
    end
    e = sb.pop_front();
    chk({tag, "/data"}, 64'(bus.data_out), 64'(e.data));
    chk({tag, "/flags"}, 64'(bus.sat_flags), 64'(e.flags));
    bus.out_ready = 1'b1;
    step();
    chk({tag, "/rel_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "/rel_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "/kept_data"}, 64'(bus.data_out), 64'(e.data));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.weight_in = '0;
    bus.bias_in   = '0;
    bus.act_mode  = 2'b00;
    bus.round_en  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    chk("rst/valid", 64'(bus.out_valid), 64'd0);
    chk("rst/data", 64'(bus.data_out), 64'd0);
    chk("rst/flags", 64'(bus.sat_flags), 64'd0);
    chk("rst/ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;

    run_vec("t1_linear", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h4000, 16'hC000, 2'b00);
    run_vec("t2_relu", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b01, 1'b0,
            0, 0, 1'b0, 16'h4000, 16'h0000, 2'b00);
    run_vec("t2_leaky", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b10, 1'b0,
            0, 0, 1'b0, 16'h4000, 16'hF800, 2'b00);
    run_vec("t2_mode11", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b11, 1'b0,
            0, 0, 1'b0, 16'h4000, 16'h0000, 2'b00);
    run_vec("t2_bias", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h1000, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h5000, 16'hC000, 2'b00);
    run_vec("t3_trunc", {4{16'h0001}}, 16'h1000, 16'h1000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    run_vec("t3_round", {4{16'h0001}}, 16'h1000, 16'h1000, 16'h0, 16'h0, 2'b00, 1'b1,
            0, 0, 1'b0, 16'h0001, 16'h0001, 2'b00);
    // -32768 is representable, so only lane 0 clamps here.
    run_vec("t4_sat_a", {4{16'h4000}}, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h7FFF, 16'h8000, 2'b01);
    run_vec("t4_sat_b", {4{16'h8000}}, 16'h4000, 16'hC000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h8000, 16'h7FFF, 2'b11);
    run_vec("mixed", {16'h2000, 16'hF000, 16'h1000, 16'h0800}, 16'h1000, 16'h8000,
            16'h0, 16'h0, 2'b00, 1'b0, 0, 0, 1'b0, 16'h0500, 16'hD800, 2'b00);
    run_vec("t5_gaps", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b00, 1'b0,
            3, 5, 1'b0, 16'h4000, 16'hC000, 2'b00);
    run_vec("t5_second", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b1, 16'h4000, 16'hC000, 2'b00);

    beat(16'h4000, 16'h2000, 16'hE000);
    beat(16'h4000, 16'h2000, 16'hE000);
    rst = 1'b0;
    step();
    chk("t6/valid", 64'(bus.out_valid), 64'd0);
    chk("t6/ready", 64'(bus.in_ready), 64'd1);
    chk("t6/data", 64'(bus.data_out), 64'd0);
    rst = 1'b1;
    run_vec("t6_fresh", {4{16'h4000}}, 16'h2000, 16'hE000, 16'h0, 16'h0, 2'b00, 1'b0,
            0, 0, 1'b0, 16'h4000, 16'hC000, 2'b00);

    for (int b = 0; b < 4; b++) beat(16'h4000, 16'h4000, 16'h2000);
    step();
    chk("hold_rst/pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b0;
    step();
    chk("hold_rst/valid", 64'(bus.out_valid), 64'd0);
    chk("hold_rst/data", 64'(bus.data_out), 64'd0);
    chk("hold_rst/flags", 64'(bus.sat_flags), 64'd0);
    chk("hold_rst/ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
